// File: rtl/narrow_sat_arbiter.sv
// narrow_sat_arbiter
//   Round-robin arbiter feeding one shared saturating narrowing stage.
//   Each requester presents a signed Q8.24 (2W-bit) accumulator value; the
//   granted one is narrowed to a signed Q4.12 (W-bit) sample, clipped to the
//   W-bit range with overflow/underflow flags, and registered with its id.
//   Saturating event counters record clip events for debug readout.
//
//   Optional build macro NARROW_SAT_ROUND_EN: round-half-up (add 2^(SHIFT-1)
//   before range check and slice) instead of truncation toward -inf.
//
// Ports
//   clk         clock, all state on posedge
//   rst         asynchronous active-low reset
//   req_valid   [N]        requester has data
//   req_data    [N*2W]     packed signed inputs, requester i at [i*2W +: 2W]
//   req_ready   [N]        one-hot grant (combinational)
//   out_valid              output register holds a result
//   out_ready              downstream accepts
//   out_data    [W]        narrowed signed result
//   out_id      [log2 N]   index of producing requester
//   out_ovf / out_udf      result clipped high / low
//   clr_counts             synchronous clear of both counters
//   ovf_count / udf_count  [CW] saturating clip-event counters
module narrow_sat_arbiter #(
  parameter int W     = 16,
  parameter int N     = 4,
  parameter int SHIFT = 12,
  parameter int CW    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           req_valid,
  input  logic [N*2*W-1:0]       req_data,
  output logic [N-1:0]           req_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W-1:0]           out_data,
  output logic [$clog2(N)-1:0]   out_id,
  output logic                   out_ovf,
  output logic                   out_udf,
  input  logic                   clr_counts,
  output logic [CW-1:0]          ovf_count,
  output logic [CW-1:0]          udf_count
);

  localparam int IW  = $clog2(N);
  localparam int EXT = 2 * W + 1;
  localparam logic signed [EXT-1:0] ONE = 1;
  localparam logic signed [EXT-1:0] LO  = -(ONE <<< (W - 1 + SHIFT));
  localparam logic signed [EXT-1:0] HI  = ((ONE <<< (W - 1)) - ONE) <<< SHIFT;

  logic [IW-1:0]  ptr_q, ptr_d;
  logic           valid_q, valid_d;
  logic [W-1:0]   data_q, data_d;
  logic [IW-1:0]  id_q, id_d;
  logic           ovf_q, ovf_d;
  logic           udf_q, udf_d;
  logic [CW-1:0]  ovf_cnt_q, ovf_cnt_d;
  logic [CW-1:0]  udf_cnt_q, udf_cnt_d;

  logic                  can_accept;
  logic                  gnt_any;
  logic [IW-1:0]         gnt_idx;
  logic [2*W-1:0]        sel_data;
  logic signed [EXT-1:0] inp_x;
  logic                  nar_ovf, nar_udf;
  logic [W-1:0]          nar_data;

  assign can_accept = !valid_q || out_ready;

  // Circular first-valid search starting at ptr_q.
  always_comb begin
    req_ready = '0;
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    if (can_accept) begin
      for (int unsigned k = 0; k < N; k++) begin
        if (!gnt_any && req_valid[(32'(ptr_q) + k) % N]) begin
          gnt_any = 1'b1;
          gnt_idx = IW'((32'(ptr_q) + k) % N);
        end
      end
    end
    if (gnt_any) req_ready[gnt_idx] = 1'b1;
  end

  assign sel_data = req_data[32'(gnt_idx) * (2 * W) +: 2 * W];

  // One extra bit keeps the optional rounding add from wrapping.
`ifdef NARROW_SAT_ROUND_EN
  assign inp_x = {sel_data[2*W-1], sel_data} + (ONE <<< (SHIFT - 1));
`else
  assign inp_x = {sel_data[2*W-1], sel_data};
`endif

  always_comb begin
    nar_udf  = (inp_x < LO);
    nar_ovf  = (inp_x > HI);
    nar_data = inp_x[W+SHIFT-1:SHIFT];
    if (nar_udf)      nar_data = {1'b1, {(W-1){1'b0}}};
    else if (nar_ovf) nar_data = {1'b0, {(W-1){1'b1}}};
  end

  always_comb begin
    ptr_d   = ptr_q;
    valid_d = valid_q;
    data_d  = data_q;
    id_d    = id_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (gnt_any) begin
      ptr_d   = (32'(gnt_idx) == N - 1) ? '0 : gnt_idx + IW'(1);
      valid_d = 1'b1;
      data_d  = nar_data;
      id_d    = gnt_idx;
      ovf_d   = nar_ovf;
      udf_d   = nar_udf;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Clear wins over a same-cycle increment; counters stick at all-ones.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    udf_cnt_d = udf_cnt_q;
    if (clr_counts) begin
      ovf_cnt_d = '0;
      udf_cnt_d = '0;
    end else if (gnt_any) begin
      if (nar_ovf && ovf_cnt_q != '1) ovf_cnt_d = ovf_cnt_q + CW'(1);
      if (nar_udf && udf_cnt_q != '1) udf_cnt_d = udf_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q     <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      id_q      <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      ovf_cnt_q <= '0;
      udf_cnt_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      id_q      <= id_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      ovf_cnt_q <= ovf_cnt_d;
      udf_cnt_q <= udf_cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_id    = id_q;
  assign out_ovf   = ovf_q;
  assign out_udf   = udf_q;
  assign ovf_count = ovf_cnt_q;
  assign udf_count = udf_cnt_q;

endmodule

// File: tb/tb_narrow_sat_arbiter.sv
// Testbench for narrow_sat_arbiter: table-driven narrowing vectors, directed
// reset / round-robin / backpressure / counter sequences, and randomized
// traffic checked every cycle against a behavioural model. A second instance
// with 2-bit counters exercises counter saturation.
`timescale 1ns/1ps
module tb_narrow_sat_arbiter;
  localparam int W = 16, N = 4, SHIFT = 12, CWA = 16, CWB = 2;
  localparam int IW = $clog2(N);

  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0]       req_valid;
  logic [N*2*W-1:0]   req_data;
  logic               out_ready;
  logic               clr_counts;

  logic [N-1:0]   a_rr, b_rr;
  logic           a_ov, b_ov;
  logic [W-1:0]   a_d, b_d;
  logic [IW-1:0]  a_id, b_id;
  logic           a_of, a_uf, b_of, b_uf;
  logic [CWA-1:0] a_oc, a_uc;
  logic [CWB-1:0] b_oc, b_uc;

  narrow_sat_arbiter #(.W(W), .N(N), .SHIFT(SHIFT), .CW(CWA)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(a_rr), .out_valid(a_ov), .out_ready(out_ready),
    .out_data(a_d), .out_id(a_id), .out_ovf(a_of), .out_udf(a_uf),
    .clr_counts(clr_counts), .ovf_count(a_oc), .udf_count(a_uc));

  narrow_sat_arbiter #(.W(W), .N(N), .SHIFT(SHIFT), .CW(CWB)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(b_rr), .out_valid(b_ov), .out_ready(out_ready),
    .out_data(b_d), .out_id(b_id), .out_ovf(b_of), .out_udf(b_uf),
    .clr_counts(clr_counts), .ovf_count(b_oc), .udf_count(b_uc));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct packed { logic [W-1:0] d; logic ovf; logic udf; } nres_t;

  function automatic nres_t narrow(input logic [2*W-1:0] x);
    nres_t  r;
    longint v, lo, hi;
    v = longint'($signed(x));
`ifdef NARROW_SAT_ROUND_EN
    v = v + (longint'(1) <<< (SHIFT - 1));
`endif
    lo = -(longint'(1) <<< (W - 1 + SHIFT));
    hi = ((longint'(1) <<< (W - 1)) - 1) <<< SHIFT;
    r = '0;
    if (v < lo) begin
      r.d = {1'b1, {(W-1){1'b0}}}; r.udf = 1'b1;
    end else if (v > hi) begin
      r.d = {1'b0, {(W-1){1'b1}}}; r.ovf = 1'b1;
    end else begin
      r.d = W'(v >>> SHIFT);
    end
    return r;
  endfunction

  bit           m_valid;
  logic [W-1:0] m_data;
  int           m_id, m_ptr;
  bit           m_ovf, m_udf;
  int           m_oca, m_uca, m_ocb, m_ucb;

  function automatic int exp_grant();
    if (m_valid && !out_ready) return -1;
    for (int k = 0; k < N; k++)
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic nres_t cur_res();
    int g = exp_grant();
    if (g < 0) return '0;
    return narrow(req_data[g*2*W +: 2*W]);
  endfunction

  function automatic int cnt_next(input int c, input int cw, input bit ev);
    if (clr_counts) return 0;
    if (ev && c < (1 << cw) - 1) return c + 1;
    return c;
  endfunction

  function automatic logic [N-1:0] exp_rr();
    int g = exp_grant();
    if (g < 0) return '0;
    return N'(1) << g;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid <= 1'b0; m_data <= '0; m_id <= 0; m_ovf <= 1'b0; m_udf <= 1'b0;
      m_ptr <= 0; m_oca <= 0; m_uca <= 0; m_ocb <= 0; m_ucb <= 0;
    end else begin
      if (exp_grant() >= 0) begin
        m_valid <= 1'b1;
        m_data  <= cur_res().d;
        m_ovf   <= cur_res().ovf;
        m_udf   <= cur_res().udf;
        m_id    <= exp_grant();
        m_ptr   <= (exp_grant() + 1) % N;
      end else if (m_valid && out_ready) begin
        m_valid <= 1'b0;
      end
      m_oca <= cnt_next(m_oca, CWA, cur_res().ovf);
      m_uca <= cnt_next(m_uca, CWA, cur_res().udf);
      m_ocb <= cnt_next(m_ocb, CWB, cur_res().ovf);
      m_ucb <= cnt_next(m_ucb, CWB, cur_res().udf);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_req_ready", a_rr, exp_rr());
      chk("m_req_ready_b", b_rr, exp_rr());
      chk("m_out_valid", a_ov, m_valid);
      chk("m_out_data", a_d, m_data);
      chk("m_out_id", a_id, m_id);
      chk("m_out_ovf", a_of, m_ovf);
      chk("m_out_udf", a_uf, m_udf);
      chk("m_ovf_count", a_oc, m_oca);
      chk("m_udf_count", a_uc, m_uca);
      chk("m_ovf_count_b", b_oc, m_ocb);
      chk("m_udf_count_b", b_uc, m_ucb);
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic [31:0] din; int rid; logic [15:0] dout; bit ovf; bit udf; int ovc; int udc;
  } vec_t;
  vec_t tbl[11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return $urandom;
      1: return 32'h07FFF000 + $urandom_range(0, 8191) - 32'd4096;
      2: return 32'hF8000000 + $urandom_range(0, 8191) - 32'd4096;
      3: return $urandom_range(0, 32'h0E000000) - 32'h07000000;
      4: return 32'h07FFF800;
      default: return 32'hFFFFF000 | $urandom_range(0, 4095);
    endcase
  endfunction

  initial begin
`ifdef NARROW_SAT_ROUND_EN
    tbl[0]  = '{32'h00123456, 1, 16'h0123, 0, 0, 0, 0};
    tbl[1]  = '{32'hF7FFFFFF, 2, 16'h8000, 0, 0, 0, 0};
    tbl[2]  = '{32'h07FFF001, 2, 16'h7FFF, 1, 0, 1, 0};
    tbl[3]  = '{32'h07FFF000, 2, 16'h7FFF, 1, 0, 2, 0};
    tbl[4]  = '{32'hF8000000, 3, 16'h8000, 0, 0, 2, 0};
    tbl[5]  = '{32'hFFFFFFFF, 0, 16'h0000, 0, 0, 2, 0};
    tbl[6]  = '{32'h80000000, 1, 16'h8000, 0, 1, 2, 1};
    tbl[7]  = '{32'h7FFFFFFF, 0, 16'h7FFF, 1, 0, 3, 1};
    tbl[8]  = '{32'h00000800, 3, 16'h0001, 0, 0, 3, 1};
    tbl[9]  = '{32'h07FFFFFF, 1, 16'h7FFF, 1, 0, 4, 1};
    tbl[10] = '{32'hF7FFF7FF, 2, 16'h8000, 0, 1, 4, 2};
`else
    tbl[0]  = '{32'h00123456, 1, 16'h0123, 0, 0, 0, 0};
    tbl[1]  = '{32'hF7FFFFFF, 2, 16'h8000, 0, 1, 0, 1};
    tbl[2]  = '{32'h07FFF001, 2, 16'h7FFF, 1, 0, 1, 1};
    tbl[3]  = '{32'h07FFF000, 2, 16'h7FFF, 0, 0, 1, 1};
    tbl[4]  = '{32'hF8000000, 3, 16'h8000, 0, 0, 1, 1};
    tbl[5]  = '{32'hFFFFFFFF, 0, 16'hFFFF, 0, 0, 1, 1};
    tbl[6]  = '{32'h80000000, 1, 16'h8000, 0, 1, 1, 2};
    tbl[7]  = '{32'h7FFFFFFF, 0, 16'h7FFF, 1, 0, 2, 2};
    tbl[8]  = '{32'h00000800, 3, 16'h0000, 0, 0, 2, 2};
    tbl[9]  = '{32'h07FFFFFF, 1, 16'h7FFF, 1, 0, 3, 2};
    tbl[10] = '{32'hF7FFF7FF, 2, 16'h8000, 0, 1, 3, 3};
`endif

    rst = 1'b0; req_valid = '0; req_data = '0; out_ready = 1'b0; clr_counts = 1'b0;
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_valid", a_ov, 0);
    chk("rst_data", a_d, 0);
    chk("rst_counts", {a_oc, a_uc}, 0);
    step();
    rst = 1'b1;

    // Round-robin: all requesters valid, one result per cycle.
    for (int i = 0; i < N; i++) req_data[i*2*W +: 2*W] = 32'h00100000 * (i + 1);
    req_valid = '1; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_grant", a_rr, 4'b0001 << (k % 4));
      if (k > 0) begin
        chk("rr_id", a_id, (k - 1) % 4);
        chk("rr_valid", a_ov, 1);
      end
    end

    // Backpressure: last grant (id 3) held while out_ready low.
    step();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_ready", a_rr, 0);
      chk("bp_id", a_id, 3);
      chk("bp_data", a_d, 16'h0400);
      chk("bp_valid", a_ov, 1);
    end
    step();
    out_ready = 1'b1;
    #1 chk("bp_release_grant", a_rr, 4'b0001);
    step();
    req_valid = '0;
    step();

    // Table-driven narrowing vectors.
    clr_counts = 1'b1;
    step();
    clr_counts = 1'b0;
    foreach (tbl[i]) begin
      req_valid = N'(1) << tbl[i].rid;
      req_data[tbl[i].rid*2*W +: 2*W] = tbl[i].din;
      step();
      req_valid = '0;
      @(negedge clk);
      chk($sformatf("vec%0d_data", i), a_d, tbl[i].dout);
      chk($sformatf("vec%0d_id", i), a_id, tbl[i].rid);
      chk($sformatf("vec%0d_ovf", i), a_of, tbl[i].ovf);
      chk($sformatf("vec%0d_udf", i), a_uf, tbl[i].udf);
      chk($sformatf("vec%0d_ovc", i), a_oc, tbl[i].ovc);
      chk($sformatf("vec%0d_udc", i), a_uc, tbl[i].udc);
      step();
    end

    // Counter saturation on 2-bit counters, then clear vs. increment.
    clr_counts = 1'b1;
    step();
    clr_counts = 1'b0;
    req_valid = 4'b0010;
    req_data[1*2*W +: 2*W] = 32'h07FFF001;
    repeat (5) step();
    req_valid = '0;
    @(negedge clk);
    chk("sat_b_ovf_count", b_oc, 3);
    chk("sat_a_ovf_count", a_oc, 5);
    step();
    req_valid = 4'b0010; clr_counts = 1'b1;
    step();
    req_valid = '0; clr_counts = 1'b0;
    @(negedge clk);
    chk("clr_win_a", a_oc, 0);
    chk("clr_win_b", b_oc, 0);
    chk("clr_win_flag", a_of, 1);

    // Asynchronous reset with a pending result; ptr returns to 0.
    step();
    req_valid = 4'b0001; req_data[0 +: 2*W] = 32'h00123456; out_ready = 1'b0;
    step();
    req_valid = '0;
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", a_ov, 0);
    chk("arst_data", a_d, 0);
    chk("arst_id", a_id, 0);
    chk("arst_flags", {a_of, a_uf}, 0);
    step();
    req_valid = '1; out_ready = 1'b1; rst = 1'b1;
    @(negedge clk);
    chk("arst_first_grant", a_rr, 4'b0001);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      step();
      req_valid  = N'($urandom);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 1) == 1) req_data[i*2*W +: 2*W] = pick();
      out_ready  = ($urandom_range(0, 3) != 0);
      clr_counts = ($urandom_range(0, 63) == 0);
    end
    step();
    req_valid = '0; clr_counts = 1'b0;
    @(negedge clk);
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
